// File: rtl/ram2_arbiter_pkg.sv
// Shared encodings and widths for the RAM2 arbiter.
// Imported by the arbiter and its interface.
package ram2_arbiter_pkg;

    localparam int MEM_ADDR_W  = 16;
    localparam int MEM_VALUE_W = 16;

    typedef logic [MEM_ADDR_W-1:0]  mem_addr_t;
    typedef logic [MEM_VALUE_W-1:0] mem_value_t;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    localparam logic OWNER_IF  = 1'b0;
    localparam logic OWNER_EXE = 1'b1;

    localparam mem_value_t TIMEOUT_FILL = 16'hFFFF;

endpackage

// File: rtl/ram2_arbiter_if.sv
// Requester, controller and status signals of the RAM2 arbiter.
// slave = arbiter side, master = pipeline/controller side.
interface ram2_arbiter_if #(
    parameter int ADDR_W = ram2_arbiter_pkg::MEM_ADDR_W,
    parameter int DATA_W = ram2_arbiter_pkg::MEM_VALUE_W
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_done;

    logic              exe_req;
    logic              exe_we;
    logic [ADDR_W-1:0] exe_addr;
    logic [DATA_W-1:0] exe_wdata;
    logic [DATA_W-1:0] exe_rdata;
    logic              exe_done;

    logic              mem_start;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_done;

    logic              busy;
    logic              owner;
    logic              err;

    modport slave (
        input  if_req, if_addr,
        input  exe_req, exe_we, exe_addr, exe_wdata,
        input  mem_rdata, mem_done,
        output if_rdata, if_done,
        output exe_rdata, exe_done,
        output mem_start, mem_we, mem_addr, mem_wdata,
        output busy, owner, err
    );

    modport master (
        output if_req, if_addr,
        output exe_req, exe_we, exe_addr, exe_wdata,
        output mem_rdata, mem_done,
        input  if_rdata, if_done,
        input  exe_rdata, exe_done,
        input  mem_start, mem_we, mem_addr, mem_wdata,
        input  busy, owner, err
    );

endinterface

// File: rtl/ram2_arbiter.sv
// Serialises IF and EXE requests onto the single-port RAM2
// controller; EXE first, with a starvation guard for IF.
module ram2_arbiter #(
    parameter int ADDR_W        = ram2_arbiter_pkg::MEM_ADDR_W,
    parameter int DATA_W        = ram2_arbiter_pkg::MEM_VALUE_W,
    parameter int IF_STARVE_MAX = 4,
    parameter int TIMEOUT_CYC   = 255
) (
    input  logic          clk,
    input  logic          rst,
    ram2_arbiter_if.slave bus
);
    import ram2_arbiter_pkg::*;

    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    localparam int SC_W = $clog2(IF_STARVE_MAX + 1);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [SC_W-1:0] SC_MAX  = SC_W'(IF_STARVE_MAX);
    localparam logic [DATA_W-1:0] FILL  = DATA_W'(TIMEOUT_FILL);

    logic [1:0]        state_q, state_d;
    logic              owner_q, owner_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] exe_rdata_q, exe_rdata_d;
    logic [SC_W-1:0]   starve_q, starve_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic              err_q, err_d;
    logic              grant_exe;

    // Next-state, arbitration, latching and read-data capture
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        exe_rdata_d = exe_rdata_q;
        starve_d    = starve_q;
        to_cnt_d    = to_cnt_q;
        err_d       = err_q;

        // IF only overrides EXE once it has lost IF_STARVE_MAX times
        grant_exe = bus.exe_req &&
                    !(bus.if_req && (starve_q == SC_MAX));

        unique case (state_q)
            ST_IDLE: begin
                starve_d = '0;
                if (bus.exe_req || bus.if_req) begin
                    state_d = ST_ISSUE;
                    if (grant_exe) begin
                        owner_d     = OWNER_EXE;
                        mem_we_d    = bus.exe_we;
                        mem_addr_d  = bus.exe_addr;
                        mem_wdata_d = bus.exe_wdata;
                        if (bus.if_req) begin
                            starve_d = (starve_q == SC_MAX) ?
                                       starve_q : starve_q + 1'b1;
                        end
                    end else begin
                        owner_d     = OWNER_IF;
                        mem_we_d    = 1'b0;
                        mem_addr_d  = bus.if_addr;
                        mem_wdata_d = '0;
                    end
                end
            end
            ST_ISSUE: begin
                to_cnt_d = '0;
                state_d  = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.mem_done) begin
                    state_d = ST_RESP;
                    if (!mem_we_q) begin
                        if (owner_q == OWNER_EXE) begin
                            exe_rdata_d = bus.mem_rdata;
                        end else begin
                            if_rdata_d = bus.mem_rdata;
                        end
                    end
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                    if (to_cnt_q == TO_LAST) begin
                        state_d = ST_RESP;
                        err_d   = 1'b1;
                        if (!mem_we_q) begin
                            if (owner_q == OWNER_EXE) begin
                                exe_rdata_d = FILL;
                            end else begin
                                if_rdata_d = FILL;
                            end
                        end
                    end
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset aborts any transaction in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWNER_IF;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            exe_rdata_q <= '0;
            starve_q    <= '0;
            to_cnt_q    <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            exe_rdata_q <= exe_rdata_d;
            starve_q    <= starve_d;
            to_cnt_q    <= to_cnt_d;
            err_q       <= err_d;
        end
    end

    assign bus.mem_start = (state_q == ST_ISSUE);
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.exe_rdata = exe_rdata_q;
    assign bus.if_done   = (state_q == ST_RESP) && (owner_q == OWNER_IF);
    assign bus.exe_done  = (state_q == ST_RESP) && (owner_q == OWNER_EXE);
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.owner     = owner_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_ram2_arbiter.sv
// Directed bench for ram2_arbiter with a small controller model
// and a scoreboard of expected completions.
module tb_ram2_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    ram2_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

    ram2_arbiter #(
        .ADDR_W(16),
        .DATA_W(16),
        .IF_STARVE_MAX(4),
        .TIMEOUT_CYC(255)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic        owner;
        logic [15:0] data;
    } exp_t;

    exp_t sb[$];

    int checks = 0;
    int passed = 0;

    logic [15:0] exp_if_rd  = 16'h0000;
    logic [15:0] exp_exe_rd = 16'h0000;

    logic ctrl_en    = 1'b1;
    logic stray_done = 1'b0;
    logic done_pend  = 1'b0;
    logic start_prev = 1'b0;

    function automatic logic [15:0] model_rd(input logic [15:0] a);
        if (a == 16'h0040) return 16'h1234;
        return a ^ 16'hA5A5;
    endfunction

    assign bus.mem_rdata = model_rd(bus.mem_addr);
    assign bus.mem_done  = done_pend | stray_done;

    // Controller model: one-cycle done after each start
    always @(posedge clk) begin
        #1;
        done_pend  = start_prev;
        start_prev = ctrl_en && bus.mem_start;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_if(input logic [15:0] a, input bit rd_ok);
        exp_t e;
        if (rd_ok) exp_if_rd = model_rd(a);
        else exp_if_rd = 16'hFFFF;
        e.owner = 1'b0;
        e.data  = exp_if_rd;
        sb.push_back(e);
    endtask

    task automatic push_exe(input logic [15:0] a, input bit we);
        exp_t e;
        if (!we) exp_exe_rd = model_rd(a);
        e.owner = 1'b1;
        e.data  = exp_exe_rd;
        sb.push_back(e);
    endtask

    task automatic wait_done(input int maxc, output int n);
        exp_t e;
        bit seen;
        seen = 0;
        n = 0;
        while (!seen && n < maxc) begin
            tick();
            n++;
            if (bus.if_done || bus.exe_done) seen = 1;
        end
        chk("done_seen", 32'(seen), 32'd1);
        if (!seen) return;
        chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        chk("owner", 32'(bus.owner), 32'(e.owner));
        chk("exe_done_who", 32'(bus.exe_done), 32'(e.owner));
        chk("if_done_who", 32'(bus.if_done), 32'(!e.owner));
        if (e.owner) begin
            chk("exe_rdata", 32'(bus.exe_rdata), 32'(e.data));
            bus.exe_req = 1'b0;
        end else begin
            chk("if_rdata", 32'(bus.if_rdata), 32'(e.data));
            bus.if_req = 1'b0;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int n;

        bus.if_req    = 1'b0;
        bus.if_addr   = '0;
        bus.exe_req   = 1'b0;
        bus.exe_we    = 1'b0;
        bus.exe_addr  = '0;
        bus.exe_wdata = '0;

        // reset state
        tick();
        tick();
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_owner", 32'(bus.owner), 0);
        chk("rst_err", 32'(bus.err), 0);
        chk("rst_start", 32'(bus.mem_start), 0);
        chk("rst_maddr", 32'(bus.mem_addr), 0);
        chk("rst_rdata", {bus.if_rdata, bus.exe_rdata}, 0);
        rst = 1'b1;
        tick();

        // IF read: start in cycle 1, done in cycle 3
        bus.if_req  = 1'b1;
        bus.if_addr = 16'h0040;
        push_if(16'h0040, 1);
        tick();
        chk("if_start", 32'(bus.mem_start), 1);
        chk("if_maddr", 32'(bus.mem_addr), 32'h0040);
        chk("if_mwe", 32'(bus.mem_we), 0);
        wait_done(10, n);
        chk("if_lat", n, 2);
        tick();
        chk("if_idle", 32'(bus.busy), 0);

        // simultaneous: EXE first, IF 4 cycles later
        bus.if_req   = 1'b1;
        bus.if_addr  = 16'h0044;
        bus.exe_req  = 1'b1;
        bus.exe_we   = 1'b0;
        bus.exe_addr = 16'h8000;
        push_exe(16'h8000, 0);
        push_if(16'h0044, 1);
        wait_done(10, n);
        chk("sim_exe_lat", n, 3);
        wait_done(10, n);
        chk("sim_if_gap", n, 4);
        tick();

        // starvation: 4 EXE grants, 1 IF, then EXE again
        bus.if_req   = 1'b1;
        bus.if_addr  = 16'h0050;
        bus.exe_req  = 1'b1;
        bus.exe_addr = 16'h8100;
        for (int i = 0; i < 4; i++) push_exe(16'h8100 + 16'(i), 0);
        push_if(16'h0050, 1);
        push_exe(16'h8104, 0);
        for (int i = 0; i < 6; i++) begin
            wait_done(10, n);
            if (i < 5) begin
                bus.exe_req  = 1'b1;
                if (i < 4) bus.exe_addr = 16'h8101 + 16'(i);
            end
        end
        tick();

        // EXE write: mem_* stable, exe_rdata untouched
        bus.exe_req   = 1'b1;
        bus.exe_we    = 1'b1;
        bus.exe_addr  = 16'h9001;
        bus.exe_wdata = 16'hBEEF;
        push_exe(16'h9001, 1);
        tick();
        chk("wr_start", 32'(bus.mem_start), 1);
        chk("wr_issue", {bus.mem_we, bus.mem_addr, bus.mem_wdata},
            {1'b1, 16'h9001, 16'hBEEF});
        tick();
        chk("wr_wait", {bus.mem_we, bus.mem_wdata}, {1'b1, 16'hBEEF});
        wait_done(10, n);
        chk("wr_resp", {bus.mem_we, bus.mem_addr, bus.mem_wdata},
            {1'b1, 16'h9001, 16'hBEEF});
        bus.exe_we = 1'b0;
        tick();
        chk("wr_one_pulse", 32'(bus.exe_done), 0);

        // timeout: controller silent, IF read
        ctrl_en     = 1'b0;
        bus.if_req  = 1'b1;
        bus.if_addr = 16'h0060;
        push_if(16'h0060, 0);
        wait_done(400, n);
        chk("to_lat", n, 257);
        chk("to_err", 32'(bus.err), 1);
        ctrl_en = 1'b1;
        tick();

        // stray mem_done in IDLE is ignored
        stray_done = 1'b1;
        tick();
        stray_done = 1'b0;
        chk("stray_busy", 32'(bus.busy), 0);
        chk("stray_if_rd", 32'(bus.if_rdata), 32'hFFFF);
        tick();
        chk("stray_done", {bus.if_done, bus.exe_done, bus.busy}, 0);
        chk("err_sticky", 32'(bus.err), 1);

        // reset in WAIT aborts without a done pulse
        ctrl_en     = 1'b0;
        bus.if_req  = 1'b1;
        bus.if_addr = 16'h0070;
        repeat (5) tick();
        chk("rw_busy", 32'(bus.busy), 1);
        rst = 1'b0;
        #1;
        chk("rw_busy0", 32'(bus.busy), 0);
        chk("rw_start0", 32'(bus.mem_start), 0);
        chk("rw_err0", 32'(bus.err), 0);
        chk("rw_rd0", {bus.if_rdata, bus.exe_rdata}, 0);
        exp_if_rd  = 16'h0000;
        exp_exe_rd = 16'h0000;
        bus.if_req = 1'b0;
        tick();
        chk("rw_nodone", {bus.if_done, bus.exe_done}, 0);
        rst     = 1'b1;
        ctrl_en = 1'b1;
        tick();
        chk("rw_nodone2", {bus.if_done, bus.exe_done}, 0);

        // normal IF read after reset
        bus.if_req  = 1'b1;
        bus.if_addr = 16'h0040;
        push_if(16'h0040, 1);
        wait_done(10, n);
        chk("post_rst_lat", n, 3);
        chk("post_rst_err", 32'(bus.err), 0);
        tick();
        chk("sb_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/ram2_arbiter.md
Name: ram2_arbiter

Overview:
- Sits between the pipeline's IF and EXE memory ports and the single-port RAM2 SRAM controller.
- Accepts one level-held request from each requester and serialises them onto the controller through a start/done handshake, one transaction in flight.
- Returns read data and a one-cycle done pulse to the owning requester.
- EXE has priority; a starvation guard guarantees IF progress. A wait timeout flags a hung controller.

Parameters:
ADDR_W, 16, address width
DATA_W, 16, data width
IF_STARVE_MAX, 4, consecutive EXE grants with IF pending before IF is forced to win once
TIMEOUT_CYC, 255, max cycles in WAIT before aborting

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  reset, asynchronous, active-low
if_req  in  1  IF fetch request, level, held until if_done
if_addr  in  ADDR_W  fetch address
if_rdata  out  DATA_W  fetched word, registered
if_done  out  1  one-cycle pulse, IF transaction complete
exe_req  in  1  EXE request, level, held until exe_done
exe_we  in  1  1=write, 0=read
exe_addr  in  ADDR_W  EXE address
exe_wdata  in  DATA_W  EXE write data
exe_rdata  out  DATA_W  EXE read word, registered
exe_done  out  1  one-cycle pulse, EXE transaction complete
mem_start  out  1  one-cycle pulse to controller
mem_we  out  1  latched write flag
mem_addr  out  ADDR_W  latched address
mem_wdata  out  DATA_W  latched write data
mem_rdata  in  DATA_W  controller read data, valid with mem_done
mem_done  in  1  one-cycle pulse from controller
busy  out  1  state != IDLE
owner  out  1  0=IF, 1=EXE; current or last grant
err  out  1  sticky timeout flag

Behaviour:
- Reset (rst low, asynchronous):
  - State IDLE.
  - All outputs 0, including rdata regs, mem_* regs and owner.
  - Starve counter 0, timeout counter 0, err 0.
  - Reset mid-transaction aborts it with no done pulse.
- States:
  - IDLE: arbitrate. If any request is pending: latch owner, addr, we (IF forces we=0), wdata; go ISSUE. Otherwise stay.
  - ISSUE: mem_start=1 for exactly this cycle; clear timeout counter; go WAIT.
  - WAIT:
    - On mem_done: capture mem_rdata into the owner's rdata reg (reads only; writes leave it unchanged); go RESP.
    - Otherwise increment the timeout counter. When it reaches TIMEOUT_CYC: set err, load 16'hFFFF into the owner's rdata (reads only), go RESP.
  - RESP: owner's done=1 for this cycle; go IDLE.
- Arbitration:
  - EXE wins when both requests are pending, unless starve_cnt == IF_STARVE_MAX; then IF wins.
  - starve_cnt increments on each EXE grant made while if_req is high.
  - starve_cnt clears on an IF grant, or in any IDLE cycle with if_req low.
  - starve_cnt saturates at IF_STARVE_MAX.
- Latency:
  - Request high in IDLE at cycle 0: mem_start high in cycle 1, earliest mem_done in cycle 2.
  - done in cycle (mem_done cycle + 1), giving 3 cycles minimum.
  - Back-to-back throughput: 4 cycles per transaction with a 1-cycle controller.
- Handshake rules:
  - A requester must drop req on the edge where it samples done=1.
  - req still high in the following IDLE cycle counts as a new request.
  - Request inputs are sampled only in IDLE; changes while busy are ignored.
  - mem_* outputs stay stable from ISSUE through RESP.
- Boundary cases:
  - mem_done outside WAIT is ignored.
  - mem_done arriving in the same cycle the timeout counter reaches TIMEOUT_CYC: mem_done wins and err is not set.
  - err clears only on reset.
  - if_rdata and exe_rdata hold their values until that requester's next read completes.

Decomposition:
- Shared package holds:
  - state encoding (IDLE, ISSUE, WAIT, RESP)
  - owner encoding (OWNER_IF=0, OWNER_EXE=1)
  - MemAddr/MemValue widths
  - timeout fill value 16'hFFFF
- Single module; no sub-module. The timeout counter width is $clog2(TIMEOUT_CYC+1).

Test Plan:
- IF read only: if_req=1, if_addr=16'h0040; controller returns 16'h1234 one cycle after mem_start -> mem_start in cycle 1, if_done in cycle 3, if_rdata=16'h1234, owner=0.
- Simultaneous requests: if_req and exe_req (read, 16'h8000) rise in the same cycle -> EXE granted first, exe_done pulses; IF granted next; IF done 4 cycles after EXE done.
- Starvation: exe_req held continuously (re-asserted after each done) with if_req high -> exactly 4 EXE grants, then one IF grant, then EXE resumes; starve_cnt returns to 0.
- EXE write: exe_we=1, addr 16'h9001, wdata 16'hBEEF -> mem_we=1, mem_wdata=16'hBEEF stable ISSUE..RESP; exe_rdata unchanged; exe_done pulses once.
- Timeout: controller never asserts mem_done, IF read -> after 255 WAIT cycles err=1, if_rdata=16'hFFFF, if_done pulses; err stays 1 until rst low.
- Reset in WAIT: drop rst mid-WAIT -> busy=0, mem_start=0, err=0 immediately; no done pulse; normal IF read succeeds after rst rises.
